// File: rtl/ide_xfer_ctrl_if.sv
// Task-file, host-port, FIFO-status and IO-controller signals of the IDE transfer sequencer.
// master drives commands and status pulses; slave is the sequencer itself.
interface ide_xfer_ctrl_if;
  logic       cmd_start;
  logic       cmd_dir;
  logic [7:0] cmd_count;
  logic       cmd_abort;
  logic       host_word;
  logic       io_sector_done;
  logic       fifo_full;
  logic       fifo_empty;
  logic       irq_ack;
  logic       fifo_reset;
  logic       drq;
  logic       irq;
  logic       io_req;
  logic       busy;
  logic       err;
  logic [8:0] sectors_left;

  modport master (
    output cmd_start, cmd_dir, cmd_count, cmd_abort, host_word, io_sector_done,
           fifo_full, fifo_empty, irq_ack,
    input  fifo_reset, drq, irq, io_req, busy, err, sectors_left
  );

  modport slave (
    input  cmd_start, cmd_dir, cmd_count, cmd_abort, host_word, io_sector_done,
           fifo_full, fifo_empty, irq_ack,
    output fifo_reset, drq, irq, io_req, busy, err, sectors_left
  );
endinterface

// File: rtl/ide_xfer_ctrl.sv
// Multi-sector ATA PIO sequencer: gates host/IO access to the sector FIFO, counts words/sectors.
// Define IDE_SECTOR_IRQ_EN to also raise irq at every sector boundary.
module ide_xfer_ctrl #(
  parameter int SECTOR_WORDS = 256
) (
  input logic           clk,
  input logic           reset,
  input logic           clk_en,
  ide_xfer_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, IO_WAIT, HOST_XFER, IO_XFER, FINISH} state_e;

  localparam logic [7:0] LAST_WORD = 8'(SECTOR_WORDS - 1);
`ifdef IDE_SECTOR_IRQ_EN
  localparam bit SECTOR_IRQ = 1'b1;
`else
  localparam bit SECTOR_IRQ = 1'b0;
`endif

  state_e     state_q, state_d;
  logic       dir_q, dir_d;
  logic [8:0] sectors_left_q, sectors_left_d;
  logic [7:0] word_cnt_q, word_cnt_d;
  logic       done_seen_q, done_seen_d;
  logic       drq_q, drq_d;
  logic       irq_q, irq_d;
  logic       io_req_q, io_req_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;
  logic       fifo_reset_q, fifo_reset_d;

  logic done_any, last_sec, in_io;

  assign done_any = done_seen_q | bus.io_sector_done;
  assign last_sec = (sectors_left_q == 9'd1);
  assign in_io    = (state_q == IO_WAIT) || (state_q == IO_XFER);

  always_comb begin
    state_d        = state_q;
    dir_d          = dir_q;
    sectors_left_d = sectors_left_q;
    word_cnt_d     = word_cnt_q;
    drq_d          = drq_q;
    io_req_d       = io_req_q;
    busy_d         = busy_q;
    err_d          = err_q;
    fifo_reset_d   = 1'b0;
    irq_d          = irq_q & ~bus.irq_ack;

    case (state_q)
      IDLE: if (bus.cmd_start) begin
        state_d        = CLEAR;
        dir_d          = bus.cmd_dir;
        sectors_left_d = (bus.cmd_count == 8'd0) ? 9'd256 : {1'b0, bus.cmd_count};
        word_cnt_d     = 8'd0;
        err_d          = 1'b0;
        busy_d         = 1'b1;
      end
      CLEAR: begin
        fifo_reset_d = 1'b1;
        if (dir_q) begin
          state_d = HOST_XFER;
          drq_d   = 1'b1;
        end else begin
          state_d  = IO_WAIT;
          io_req_d = 1'b1;
        end
      end
      IO_WAIT: if (done_any && bus.fifo_full) begin
        state_d    = HOST_XFER;
        io_req_d   = 1'b0;
        drq_d      = 1'b1;
        word_cnt_d = 8'd0;
        if (SECTOR_IRQ) irq_d = 1'b1;
      end
      HOST_XFER: if (bus.host_word) begin
        word_cnt_d = word_cnt_q + 8'd1;
        if (word_cnt_q == LAST_WORD) begin
          // drq drops on the same edge that counts the last word of the sector
          word_cnt_d = 8'd0;
          drq_d      = 1'b0;
          if (dir_q) begin
            state_d  = IO_XFER;
            io_req_d = 1'b1;
          end else begin
            sectors_left_d = sectors_left_q - 9'd1;
            if (last_sec) begin
              state_d = FINISH;
            end else begin
              state_d  = IO_WAIT;
              io_req_d = 1'b1;
            end
          end
        end
      end
      IO_XFER: if (done_any && bus.fifo_empty) begin
        io_req_d       = 1'b0;
        sectors_left_d = sectors_left_q - 9'd1;
        if (last_sec) begin
          state_d = FINISH;
        end else begin
          state_d    = HOST_XFER;
          drq_d      = 1'b1;
          word_cnt_d = 8'd0;
          if (SECTOR_IRQ) irq_d = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
        irq_d   = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // abort overrides any transition; sectors_left keeps the progress made so far
    if (bus.cmd_abort && (state_q != IDLE)) begin
      state_d        = IDLE;
      sectors_left_d = sectors_left_q;
      fifo_reset_d   = 1'b1;
      err_d          = 1'b1;
      irq_d          = 1'b1;
      drq_d          = 1'b0;
      io_req_d       = 1'b0;
      busy_d         = 1'b0;
    end

    done_seen_d = in_io && (state_d == state_q) && done_any;
  end

  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (reset) begin
        state_q        <= IDLE;
        dir_q          <= 1'b0;
        sectors_left_q <= 9'd0;
        word_cnt_q     <= 8'd0;
        done_seen_q    <= 1'b0;
        drq_q          <= 1'b0;
        irq_q          <= 1'b0;
        io_req_q       <= 1'b0;
        busy_q         <= 1'b0;
        err_q          <= 1'b0;
        fifo_reset_q   <= 1'b0;
      end else begin
        state_q        <= state_d;
        dir_q          <= dir_d;
        sectors_left_q <= sectors_left_d;
        word_cnt_q     <= word_cnt_d;
        done_seen_q    <= done_seen_d;
        drq_q          <= drq_d;
        irq_q          <= irq_d;
        io_req_q       <= io_req_d;
        busy_q         <= busy_d;
        err_q          <= err_d;
        fifo_reset_q   <= fifo_reset_d;
      end
    end
  end

  assign bus.fifo_reset   = fifo_reset_q;
  assign bus.drq          = drq_q;
  assign bus.irq          = irq_q;
  assign bus.io_req       = io_req_q;
  assign bus.busy         = busy_q;
  assign bus.err          = err_q;
  assign bus.sectors_left = sectors_left_q;
endmodule

// File: tb/tb_ide_xfer_ctrl.sv
// Bench for ide_xfer_ctrl: per-sector word counts and end-of-transfer status go through scoreboard queues.
module tb_ide_xfer_ctrl;
  localparam int SW = 256;
`ifdef IDE_SECTOR_IRQ_EN
  localparam bit SEC_IRQ = 1'b1;
`else
  localparam bit SEC_IRQ = 1'b0;
`endif

  typedef struct packed {
    logic       err;
    logic       irq;
    logic [8:0] sl;
  } done_t;

  logic clk = 1'b0;
  logic reset;
  logic clk_en;
  bit   slow;
  int   n_chk = 0;
  int   n_err = 0;
  int   exp_words[$];
  done_t exp_done[$];

  ide_xfer_ctrl_if bus();

  ide_xfer_ctrl #(.SECTOR_WORDS(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .clk_en(clk_en),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one enabled edge; in slow mode two disabled edges come first, with a stray host_word held high
  task automatic cyc();
    logic hw;
    if (slow) begin
      hw            = bus.host_word;
      bus.host_word = 1'b1;
      clk_en        = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      bus.host_word = hw;
      clk_en        = 1'b1;
    end
    @(posedge clk); #1;
    bus.cmd_start      = 1'b0;
    bus.cmd_abort      = 1'b0;
    bus.host_word      = 1'b0;
    bus.io_sector_done = 1'b0;
    bus.irq_ack        = 1'b0;
  endtask

  // monitor: words accepted per drq window, status at every busy fall
  int   wcnt = 0;
  logic drq_p = 1'b0;
  logic busy_p = 1'b0;
  always @(negedge clk) begin : mon
    done_t e;
    if (drq_p === 1'b1 && bus.drq === 1'b0) begin
      if (exp_words.size() == 0) chk("sb_words_underflow", 1, 0);
      else chk("sb_words", wcnt, exp_words.pop_front());
      wcnt = 0;
    end
    if (busy_p === 1'b1 && bus.busy === 1'b0) begin
      if (exp_done.size() == 0) chk("sb_done_underflow", 1, 0);
      else begin
        e = exp_done.pop_front();
        chk("sb_err", bus.err, e.err);
        chk("sb_irq", bus.irq, e.irq);
        chk("sb_sectors_left", bus.sectors_left, e.sl);
      end
    end
    if (bus.drq === 1'b1 && bus.host_word === 1'b1 && clk_en === 1'b1) wcnt++;
    drq_p  = bus.drq;
    busy_p = bus.busy;
  end

  // stop_sec=0: full transfer; otherwise abort (or reset) after stop_words words of sector stop_sec
  task automatic run_xfer(input bit dir, input int cnt, input int stop_sec, input int stop_words,
                          input bit use_rst);
    done_t e;
    int    nw;
    if (stop_sec == 0)  e = '{err: 1'b0, irq: 1'b1, sl: 9'd0};
    else if (use_rst)   e = '{err: 1'b0, irq: 1'b0, sl: 9'd0};
    else                e = '{err: 1'b1, irq: 1'b1, sl: 9'(cnt - stop_sec + 1)};
    exp_done.push_back(e);

    bus.cmd_start = 1'b1;
    bus.cmd_dir   = dir;
    bus.cmd_count = 8'(cnt);
    cyc();
    chk("start_busy", bus.busy, 1);
    chk("start_err_clr", bus.err, 0);
    chk("start_sl", bus.sectors_left, cnt);
    chk("start_no_frst", bus.fifo_reset, 0);
    cyc();
    chk("clr_frst", bus.fifo_reset, 1);
    chk("clr_drq", bus.drq, dir);
    chk("clr_ioreq", bus.io_req, !dir);

    for (int s = 1; s <= cnt; s++) begin
      if (!dir) begin
        if (s <= 2) begin
          cyc();
          chk("rd_wait_ioreq", bus.io_req, 1);
          chk("rd_wait_drq", bus.drq, 0);
          chk("rd_frst_once", bus.fifo_reset, 0);
          bus.io_sector_done = 1'b1;
          cyc();
          chk("rd_done_latched", bus.io_req, 1);
          bus.fifo_full = 1'b1;
          cyc();
        end else begin
          bus.io_sector_done = 1'b1;
          bus.fifo_full      = 1'b1;
          cyc();
        end
        bus.fifo_full = 1'b0;
        chk("rd_drq_up", bus.drq, 1);
        chk("rd_ioreq_dn", bus.io_req, 0);
        chk("rd_sec_irq", bus.irq, SEC_IRQ);
      end

      nw = (s == stop_sec) ? stop_words : SW;
      exp_words.push_back(nw);
      for (int w = 0; w < nw; w++) begin
        bus.host_word = 1'b1;
        if (w == 0) begin
          bus.irq_ack = 1'b1;
          if (s == 1) begin
            bus.cmd_start = 1'b1;
            bus.cmd_dir   = !dir;
            bus.cmd_count = 8'd7;
          end
        end
        cyc();
        if (w == 0) chk("ack_irq", bus.irq, 0);
        if (w == SW - 2 && nw == SW) chk("drq_before_last", bus.drq, 1);
      end

      if (s == stop_sec) begin
        if (use_rst) begin
          reset = 1'b1;
          cyc();
          reset = 1'b0;
          chk("rst_busy", bus.busy, 0);
          chk("rst_drq", bus.drq, 0);
          chk("rst_irq", bus.irq, 0);
          chk("rst_ioreq", bus.io_req, 0);
          chk("rst_err", bus.err, 0);
          chk("rst_frst", bus.fifo_reset, 0);
          chk("rst_sl", bus.sectors_left, 0);
        end else begin
          bus.cmd_abort = 1'b1;
          cyc();
          chk("ab_drq", bus.drq, 0);
          chk("ab_ioreq", bus.io_req, 0);
          chk("ab_busy", bus.busy, 0);
          chk("ab_err", bus.err, 1);
          chk("ab_irq", bus.irq, 1);
          chk("ab_frst", bus.fifo_reset, 1);
          chk("ab_sl", bus.sectors_left, cnt - s + 1);
          cyc();
          chk("ab_frst_once", bus.fifo_reset, 0);
          bus.irq_ack = 1'b1;
          cyc();
          chk("ab_irq_ack", bus.irq, 0);
        end
        return;
      end

      chk("last_word_drq", bus.drq, 0);
      if (!dir) begin
        chk("rd_sl_dec", bus.sectors_left, cnt - s);
        chk("rd_next_ioreq", bus.io_req, s < cnt);
      end else begin
        chk("wr_ioreq", bus.io_req, 1);
        chk("wr_sl_hold", bus.sectors_left, cnt - s + 1);
        if (s == 1) begin
          bus.host_word      = 1'b1;
          bus.io_sector_done = 1'b1;
          cyc();
          chk("wr_done_latched", bus.io_req, 1);
          bus.fifo_empty = 1'b1;
          cyc();
        end else begin
          bus.io_sector_done = 1'b1;
          bus.fifo_empty     = 1'b1;
          cyc();
        end
        bus.fifo_empty = 1'b0;
        chk("wr_ioreq_dn", bus.io_req, 0);
        chk("wr_sl_dec", bus.sectors_left, cnt - s);
        chk("wr_next_drq", bus.drq, s < cnt);
        chk("wr_sec_irq", bus.irq, SEC_IRQ && (s < cnt));
      end
    end

    chk("fin_busy_hold", bus.busy, 1);
    chk("fin_irq_pending", bus.irq, 0);
    bus.irq_ack = 1'b1;
    cyc();
    chk("fin_irq_set_wins", bus.irq, 1);
    chk("fin_busy_dn", bus.busy, 0);
    chk("fin_sl", bus.sectors_left, 0);
    bus.irq_ack = 1'b1;
    cyc();
    chk("irq_ack_clr", bus.irq, 0);
  endtask

  initial begin
    bus.cmd_start      = 1'b0;
    bus.cmd_dir        = 1'b0;
    bus.cmd_count      = 8'd0;
    bus.cmd_abort      = 1'b0;
    bus.host_word      = 1'b0;
    bus.io_sector_done = 1'b0;
    bus.fifo_full      = 1'b0;
    bus.fifo_empty     = 1'b0;
    bus.irq_ack        = 1'b0;
    reset  = 1'b1;
    clk_en = 1'b1;
    slow   = 1'b0;
    cyc();
    cyc();
    chk("reset_busy", bus.busy, 0);
    chk("reset_drq", bus.drq, 0);
    chk("reset_irq", bus.irq, 0);
    chk("reset_ioreq", bus.io_req, 0);
    chk("reset_err", bus.err, 0);
    chk("reset_frst", bus.fifo_reset, 0);
    chk("reset_sl", bus.sectors_left, 0);
    reset = 1'b0;

    bus.cmd_abort = 1'b1;
    cyc();
    chk("idle_abort_busy", bus.busy, 0);
    chk("idle_abort_err", bus.err, 0);
    chk("idle_abort_irq", bus.irq, 0);
    chk("idle_abort_frst", bus.fifo_reset, 0);
    bus.host_word      = 1'b1;
    bus.io_sector_done = 1'b1;
    cyc();
    chk("idle_drq", bus.drq, 0);
    chk("idle_ioreq", bus.io_req, 0);

    run_xfer(1'b0, 2, 0, 0, 1'b0);
    run_xfer(1'b1, 1, 0, 0, 1'b0);
    run_xfer(1'b1, 3, 2, 100, 1'b0);
    run_xfer(1'b1, 1, 0, 0, 1'b0);
    slow = 1'b1;
    run_xfer(1'b1, 1, 0, 0, 1'b0);
    run_xfer(1'b0, 2, 0, 0, 1'b0);
    slow = 1'b0;
    run_xfer(1'b0, 2, 1, 37, 1'b1);
    run_xfer(1'b0, 3, 0, 0, 1'b0);
    run_xfer(1'b0, 256, 0, 0, 1'b0);
    repeat (2) cyc();

    chk("sb_words_empty", exp_words.size(), 0);
    chk("sb_done_empty", exp_done.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
